// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit limits,
// slot index width and the active-high hex-to-segment table.
package seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int SLOT_W     = 3;

  // Segment patterns for 0..F, bit order g f e d c b a, 1 = segment lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between a display data source (master) and the scan controller (slave).
//
// Handshake: load is a single-cycle strobe with no ready/ack. On any rising
// edge where load=1 the slave captures value, dp_mask, blank_mask and lzs
// together; when load=0 those signals are ignored and may change freely.
// an, seg and slot are continuously driven by the slave.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  import seg_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lzs;
  logic [DIGITS-1:0]     an;
  logic [7:0]            seg;
  logic [SLOT_W-1:0]     slot;

  modport master (
    output load, value, dp_mask, blank_mask, lzs,
    input  an, seg, slot
  );

  modport slave (
    input  load, value, dp_mask, blank_mask, lzs,
    output an, seg, slot
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder; output is active-high with the
// decimal point in bit 7.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  // Table lookup plus the decimal point bit.
  assign o_seg = {i_dp, HEX_SEG[i_nibble]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment display scanner. A refresh counter splits
// time into DIV-cycle slots; each slot drives one digit after a short
// blanking window that suppresses ghosting between digits. Display data is
// held in shadow registers loaded by a strobe. an/seg are registered and
// lag the counter/slot by one cycle.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIV     = 65536,
  parameter int DEAD    = 1,
  parameter int AN_LOW  = 1,
  parameter int SEG_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   DEAD_C   = CNT_W'(DEAD);
  localparam logic [SLOT_W-1:0]  SLOT_MAX = SLOT_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  AN_OFF   = (AN_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]         SEG_OFF  = (SEG_LOW != 0) ? 8'hFF : 8'h00;

  // Shadow registers
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp_mask;
  logic [DIGITS-1:0]   r_blank_mask;
  logic                r_lzs;

  // Scan state
  logic [CNT_W-1:0]    r_cnt;
  logic [SLOT_W-1:0]   r_slot;

  // Output registers
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;

  logic                w_tick;
  logic                w_dead;
  logic [DIGITS-1:0]   w_lz;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [DIGITS-1:0]   w_an_act;
  logic [7:0]          w_dec;
  logic [7:0]          w_seg_act;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_dead = (DEAD > 0) && (r_cnt < DEAD_C);

  // Capture display data only on a load strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value      <= '0;
      r_dp_mask    <= '0;
      r_blank_mask <= '0;
      r_lzs        <= 1'b0;
    end else if (bus.load) begin
      r_value      <= bus.value;
      r_dp_mask    <= bus.dp_mask;
      r_blank_mask <= bus.blank_mask;
      r_lzs        <= bus.lzs;
    end
  end

  // Refresh counter wraps every DIV cycles; each wrap advances the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      if ((DIGITS == 1) || (r_slot == SLOT_MAX)) r_slot <= '0;
      else                                        r_slot <= r_slot + SLOT_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Digit i is a leading zero when it and every higher nibble are zero.
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_lz   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_zero  = v_zero & (r_value[4*i +: 4] == 4'h0);
      w_lz[i] = v_zero;
    end
  end

  // Pick the nibble, dp, blanking and anode for the current slot.
  always_comb begin
    w_nib    = r_value[3:0];
    w_dp     = r_dp_mask[0];
    w_blank  = r_blank_mask[0];
    w_an_act = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_nib    = r_value[4*i +: 4];
        w_dp     = r_dp_mask[i];
        w_blank  = r_blank_mask[i] | (r_lzs & w_lz[i] & (i != 0));
        w_an_act = DIGITS'(1) << i;
      end
    end
  end

  seg_hex_decode u_dec (
    .i_nibble (w_nib),
    .i_dp     (w_dp),
    .o_seg    (w_dec)
  );

  // A blanked digit keeps its anode and decimal point but no a-g segments.
  assign w_seg_act = w_blank ? {w_dp, 7'h00} : w_dec;

  // Register the outputs with polarity applied; dead time forces all off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else if (w_dead) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= (AN_LOW  != 0) ? ~w_an_act  : w_an_act;
      r_seg <= (SEG_LOW != 0) ? ~w_seg_act : w_seg_act;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.slot = r_slot;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, DIV=4, DEAD=1, active-low outputs).
// Expected outputs come from a cycle-count model: after reset release, the
// output following edge n reflects scan position n-1 and the display data
// loaded on edges before edge n.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int DEAD   = 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS  (DIGITS),
    .DIV     (DIV),
    .DEAD    (DEAD),
    .AN_LOW  (1),
    .SEG_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_q[$];

  // Reference model state
  int          n_edges;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [3:0]  m_bm;
  logic        m_lzs;

  // Driver values, applied at the next falling edge
  logic        d_rst;
  logic        d_load;
  logic [15:0] d_value;
  logic [3:0]  d_dp;
  logic [3:0]  d_bm;
  logic        d_lzs;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {an, seg} for scan position k using the current model data.
  function automatic logic [11:0] model_out(input int k);
    int         cnt;
    int         sl;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] s;
    logic [3:0] a;
    cnt = k % DIV;
    sl  = (k / DIV) % DIGITS;
    if (cnt < DEAD) return {4'hF, 8'hFF};
    nib   = m_value[4*sl +: 4];
    blank = m_bm[sl] || (m_lzs && (sl > 0) && ((m_value >> (4*sl)) == 16'h0));
    s     = {m_dp[sl], blank ? 7'h00 : hex_tab[nib]};
    a     = 4'b0001 << sl;
    return {~a, ~s};
  endfunction

  // One clock: drive at negedge, sample 1 time unit after posedge, compare.
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    rst            = d_rst;
    bus.load       = d_load;
    bus.value      = d_value;
    bus.dp_mask    = d_dp;
    bus.blank_mask = d_bm;
    bus.lzs        = d_lzs;
    @(posedge clk);
    #1;
    if (!d_rst) begin
      exp_q.push_back({4'hF, 8'hFF});
      n_edges = 0;
      m_value = '0; m_dp = '0; m_bm = '0; m_lzs = 1'b0;
    end else begin
      exp_q.push_back(model_out(n_edges));
      if (d_load) begin
        m_value = d_value; m_dp = d_dp; m_bm = d_bm; m_lzs = d_lzs;
      end
      n_edges++;
    end
    e = exp_q.pop_front();
    check("an",   32'(bus.an),   32'(e[11:8]));
    check("seg",  32'(bus.seg),  32'(e[7:0]));
    check("slot", 32'(bus.slot), 32'((n_edges / DIV) % DIGITS));
    d_load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic load_data(input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] bm, input logic lz);
    d_load = 1'b1; d_value = v; d_dp = dp; d_bm = bm; d_lzs = lz;
    step();
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0; bus.blank_mask = '0; bus.lzs = 1'b0;
    d_rst = 1'b0; d_load = 1'b0; d_value = '0; d_dp = '0; d_bm = '0; d_lzs = 1'b0;
    n_edges = 0; m_value = '0; m_dp = '0; m_bm = '0; m_lzs = 1'b0;

    // Reset held: outputs inactive, loads ignored
    d_value = 16'hBEEF;
    d_load  = 1'b1;
    run(3);
    check("rst_an",  32'(bus.an),  32'h0000000F);
    check("rst_seg", 32'(bus.seg), 32'h000000FF);

    // Basic scan: load on the first cycle after release
    d_rst = 1'b1;
    load_data(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    run(20);

    // Leading-zero suppression
    load_data(16'h0005, 4'b0000, 4'b0000, 1'b1);
    run(16);
    load_data(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run(16);

    // Forced blank and decimal points
    load_data(16'h4321, 4'b0110, 4'b0100, 1'b0);
    run(16);

    // Load exactly on the tick ending slot 0
    load_data(16'h5678, 4'b0000, 4'b0000, 1'b0);
    guard = 0;
    while (!(((n_edges % DIV) == DIV - 1) && (((n_edges / DIV) % DIGITS) == 0)) && guard < 64) begin
      step();
      guard++;
    end
    check("tick_align", 32'(guard < 64), 32'h1);
    load_data(16'h3333, 4'b0000, 4'b0000, 1'b0);
    run(20);

    // Load during dead time
    guard = 0;
    while (((n_edges % DIV) != 0) && guard < 16) begin
      step();
      guard++;
    end
    load_data(16'h0A0B, 4'b1001, 4'b0000, 1'b1);
    run(12);

    // Randomised loads; unloaded input changes must not leak through
    for (int i = 0; i < 300; i++) begin
      logic [15:0] tmp;
      tmp     = 16'($urandom);
      d_load  = ($urandom_range(0, 3) == 0);
      d_value = tmp >> (4 * $urandom_range(0, 4));
      d_dp    = 4'($urandom_range(0, 15));
      d_bm    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d_lzs   = 1'($urandom_range(0, 1));
      step();
    end

    // Asynchronous reset in the middle of slot 2
    load_data(16'h9876, 4'b0000, 4'b0000, 1'b0);
    guard = 0;
    while (!(((n_edges % DIV) == 2) && (((n_edges / DIV) % DIGITS) == 2)) && guard < 64) begin
      step();
      guard++;
    end
    check("async_align", 32'(bus.an), 32'h0000000B);
    #2;
    rst = 1'b0;
    #1;
    check("async_an",   32'(bus.an),   32'h0000000F);
    check("async_seg",  32'(bus.seg),  32'h000000FF);
    check("async_slot", 32'(bus.slot), 32'h0);
    d_rst = 1'b0;
    run(2);
    d_rst = 1'b1;
    step();
    step();
    check("post_rst_an", 32'(bus.an), 32'h0000000E);
    run(14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV, default 65536: clk cycles per digit slot, legal range 4..2^20.
REQ-003 Parameter DEAD, default 1: blanking cycles at the start of each slot, legal range 0..DIV-2.
REQ-004 Parameter AN_LOW, default 1: anode outputs are active-low when 1.
REQ-005 Parameter SEG_LOW, default 1: segment outputs are active-low when 1.
REQ-006 clk  in  1  the single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-low.
REQ-008 load  in  1  one-cycle strobe that captures value, dp_mask, blank_mask and lzs.
REQ-009 value  in  4*DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is least significant.
REQ-010 dp_mask  in  DIGITS  decimal point enable per digit.
REQ-011 blank_mask  in  DIGITS  forced blank per digit.
REQ-012 lzs  in  1  leading-zero suppression enable.
REQ-013 an  out  DIGITS  digit enables, one-hot active or all inactive.
REQ-014 seg  out  8  segments, bit 7 = dp, bits 6..0 = g..a.
REQ-015 slot  out  3  index of the digit currently being scanned.

Function
REQ-016 Shadow registers SHALL capture all load-qualified inputs on the edge where load=1; the captured data is visible on an/seg from the next refresh-register update. The block SHALL NOT sample these inputs at any other time.
REQ-017 Refresh counter SHALL count 0..DIV-1 and wrap to 0; a tick SHALL occur in the cycle where counter==DIV-1.
REQ-018 On a tick, slot SHALL advance by 1 and wrap from DIGITS-1 to 0. When DIGITS=1, slot SHALL remain 0.
REQ-019 While counter<DEAD, an SHALL be all inactive and seg SHALL be all off, to prevent ghosting.
REQ-020 Otherwise, an SHALL assert only bit slot, and seg SHALL carry the hex pattern of nibble slot (0-F, standard a-g patterns) with dp = dp_mask[slot].
REQ-021 Digit i SHALL be blanked (segments off, anode still active) if blank_mask[i]=1.
REQ-022 Digit i SHALL also be blanked if lzs=1, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 SHALL never be zero-suppressed.
REQ-023 A blanked digit SHALL still show dp when dp_mask[i]=1.
REQ-024 an and seg SHALL be registered outputs, lagging counter/slot by exactly one cycle.
REQ-025 Polarity SHALL be applied at the output register according to AN_LOW and SEG_LOW.
REQ-026 A load coinciding with a tick SHALL take effect for the new slot, not the old one.
REQ-027 A load during a dead-time cycle SHALL be captured normally.

Reset
REQ-028 While rst=0, the block SHALL hold: counter=0, slot=0, shadow registers=0, lzs=0, an all inactive, seg all off.
REQ-029 These values SHALL apply asynchronously when rst asserts, including mid-slot and mid-dead-time.
REQ-030 After rst deasserts, scanning SHALL restart at slot 0 with counter 0.

Structure
REQ-031 A shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table (active-high) and the constants for maximum DIGITS (8) and slot width (3).
REQ-032 One combinational sub-module seg_hex_decode (nibble, dp in -> 8-bit active-high pattern out) SHALL be instantiated once, on the selected nibble.
REQ-033 The refresh counter width SHALL be $clog2(DIV).

Verification
REQ-034 Reset scan: DIGITS=4, DIV=4, DEAD=1, active-low; load value=16'h12AF.
- Per slot: one cycle of an=4'b1111, then three cycles of an=1110, 1101, 1011, 0111 in turn.
- seg SHALL show F, A, 2, 1 on those slots.
REQ-035 Leading-zero suppression: lzs=1, value=16'h0005.
- Digits 3..1 SHALL have segments off with their anodes still driven.
- Digit 0 SHALL show 5.
- With value=16'h0000, digit 0 SHALL show 0.
REQ-036 Masks: blank_mask=4'b0100 and dp_mask=4'b0110.
- Digit 2 SHALL show dp only.
- Digit 1 SHALL show its nibble plus dp.
REQ-037 Load on tick: load value=16'h3333 in the cycle counter==3 of slot 0.
- Slot 1 SHALL show 3 from its first active cycle.
- Slot 0 SHALL never show 3 before the next wrap.
REQ-038 Async reset: assert rst=0 mid-slot 2, between clock edges.
- an SHALL go to 4'b1111 and seg to 8'hFF with no clock edge.
- After release, slot 0 SHALL be active at cycle DEAD+1.
